pe_dot_packed_mac: RTL and testbench

Parametrised packed sign-magnitude dot-product MAC for the PE array. Each cycle it takes two packed feature vectors and two packed filter vectors of `DOT_SIZE` elements and forms all four feature×filter dot products. It accumulates them over a burst delimited by `i_last` and emits four saturated signed sums with a valid pulse. It extends the 2×2 packed-multiplier datapath with generic magnitude width, dot reduction, burst accumulation, overflow flags and a valid pipeline.

---
 rtl/pe_dot_packed_mac.sv | 247 ++++++++++++++++++++++++
 tb/tb_pe_dot_packed_mac.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_dot_packed_mac.sv
// rtl/pe_dot_packed_mac.sv - packed sign-magnitude 2x2 dot-product MAC with burst accumulation
//
// Purpose:
//   Each accepted beat carries two feature vectors and two filter vectors of
//   DOT_SIZE sign-magnitude operands. All four feature x filter dot products
//   are formed, summed over a burst delimited by i_last, saturated to
//   ACC_WIDTH, and presented with a one-cycle o_valid pulse.
//
// Pipeline (L = MULT_LATENCY + 2 edges from input sample to o_valid):
//   input register -> MULT_LATENCY multiply registers -> reduce register
//   -> accumulate / output register.
//
// Ports:
//   clock       sole clock, rising edge
//   reset       synchronous, active-high
//   i_valid     input beat valid
//   i_last      final beat of a burst (qualified by i_valid)
//   i_feature   [f][d] sign-magnitude features, sign in MSB
//   i_filter    [g][d] sign-magnitude filters, sign in MSB
//   o_valid     one-cycle pulse when a burst result is presented
//   o_result    [f][g] saturated signed burst sums
//   o_overflow  [f][g] sticky saturation flag for the presented burst

module pe_dot_packed_mac #(
  parameter int DOT_SIZE     = 4,
  parameter int MAG_WIDTH    = 3,
  parameter int MULT_LATENCY = 3,
  parameter int ACC_WIDTH    = 16
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic                                    i_valid,
  input  logic                                    i_last,
  input  logic [1:0][DOT_SIZE-1:0][MAG_WIDTH:0]   i_feature,
  input  logic [1:0][DOT_SIZE-1:0][MAG_WIDTH:0]   i_filter,
  output logic                                    o_valid,
  output logic [1:0][1:0][ACC_WIDTH-1:0]          o_result,
  output logic [1:0][1:0]                         o_overflow
);

  localparam int PROD_W = 2 * MAG_WIDTH;
  localparam int PKY_W  = 3 * MAG_WIDTH;
  localparam int PK_W   = 4 * MAG_WIDTH;
  localparam int SUM_W  = PROD_W + $clog2(DOT_SIZE) + 1;
  localparam int ADD_W  = ((ACC_WIDTH > SUM_W) ? ACC_WIDTH : SUM_W) + 1;

  localparam logic [ADD_W-1:0] ACC_MAX = {{(ADD_W-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ADD_W-1:0] ACC_MIN = ~ACC_MAX;

  // ---------------------------------------------------------------------------
  // Input register
  // ---------------------------------------------------------------------------
  logic                                  in_valid_q;
  logic                                  in_last_q;
  logic [1:0][DOT_SIZE-1:0][MAG_WIDTH:0] in_feat_q;
  logic [1:0][DOT_SIZE-1:0][MAG_WIDTH:0] in_filt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      in_valid_q <= 1'b0;
      in_last_q  <= 1'b0;
      in_feat_q  <= '0;
      in_filt_q  <= '0;
    end else begin
      in_valid_q <= i_valid;
      // i_last without i_valid is meaningless; drop it here so later stages
      // only ever see a qualified last.
      in_last_q  <= i_valid & i_last;
      in_feat_q  <= i_feature;
      in_filt_q  <= i_filter;
    end
  end

  // ---------------------------------------------------------------------------
  // Packed multiply
  //
  // Both filter magnitudes for element d are packed into one operand with
  // g0 in the low 2*MAG_WIDTH-bit field and g1 in the field above it. One
  // multiply per feature element then yields |f|*|g0| in the low field and
  // |f|*|g1| in the high field. Each field is exactly as wide as the largest
  // possible product ((2^M-1)^2 < 2^(2M)), so the low product can never
  // carry into the high field and no overlap correction is needed, even for
  // all-ones magnitudes.
  // ---------------------------------------------------------------------------
  logic [DOT_SIZE-1:0][PKY_W-1:0]               pk_y;
  logic [1:0][DOT_SIZE-1:0][PK_W-1:0]           pk_p;
  logic [1:0][1:0][DOT_SIZE-1:0][PROD_W-1:0]    mag_d;
  logic [1:0][1:0][DOT_SIZE-1:0]                sgn_d;

  always_comb begin
    pk_y  = '0;
    pk_p  = '0;
    mag_d = '0;
    sgn_d = '0;
    for (int d = 0; d < DOT_SIZE; d++) begin
      pk_y[d] = {in_filt_q[1][d][MAG_WIDTH-1:0], {MAG_WIDTH{1'b0}}, in_filt_q[0][d][MAG_WIDTH-1:0]};
    end
    for (int f = 0; f < 2; f++) begin
      for (int d = 0; d < DOT_SIZE; d++) begin
        pk_p[f][d]     = PK_W'(in_feat_q[f][d][MAG_WIDTH-1:0]) * PK_W'(pk_y[d]);
        mag_d[f][0][d] = pk_p[f][d][PROD_W-1:0];
        mag_d[f][1][d] = pk_p[f][d][PK_W-1:PROD_W];
        for (int g = 0; g < 2; g++) begin
          sgn_d[f][g][d] = in_feat_q[f][d][MAG_WIDTH] ^ in_filt_q[g][d][MAG_WIDTH];
        end
      end
    end
  end

  // Multiply pipeline: stage 0 captures the products, later stages delay them.
  logic [MULT_LATENCY-1:0]                                   mv_q;
  logic [MULT_LATENCY-1:0]                                   ml_q;
  logic [MULT_LATENCY-1:0][1:0][1:0][DOT_SIZE-1:0][PROD_W-1:0] mmag_q;
  logic [MULT_LATENCY-1:0][1:0][1:0][DOT_SIZE-1:0]           msgn_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      mv_q   <= '0;
      ml_q   <= '0;
      mmag_q <= '0;
      msgn_q <= '0;
    end else begin
      mv_q[0]   <= in_valid_q;
      ml_q[0]   <= in_last_q;
      mmag_q[0] <= mag_d;
      msgn_q[0] <= sgn_d;
      for (int s = 1; s < MULT_LATENCY; s++) begin
        mv_q[s]   <= mv_q[s-1];
        ml_q[s]   <= ml_q[s-1];
        mmag_q[s] <= mmag_q[s-1];
        msgn_q[s] <= msgn_q[s-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Reduce: signed sum over d at full precision. A negative zero contributes
  // -0 = 0, so it needs no special handling.
  // ---------------------------------------------------------------------------
  logic [1:0][1:0][SUM_W-1:0] dot_d;

  always_comb begin
    dot_d = '0;
    for (int f = 0; f < 2; f++) begin
      for (int g = 0; g < 2; g++) begin
        for (int d = 0; d < DOT_SIZE; d++) begin
          if (msgn_q[MULT_LATENCY-1][f][g][d]) begin
            dot_d[f][g] = dot_d[f][g] - SUM_W'(mmag_q[MULT_LATENCY-1][f][g][d]);
          end else begin
            dot_d[f][g] = dot_d[f][g] + SUM_W'(mmag_q[MULT_LATENCY-1][f][g][d]);
          end
        end
      end
    end
  end

  logic                       rv_q;
  logic                       rl_q;
  logic [1:0][1:0][SUM_W-1:0] rdot_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      rv_q   <= 1'b0;
      rl_q   <= 1'b0;
      rdot_q <= '0;
    end else begin
      rv_q   <= mv_q[MULT_LATENCY-1];
      rl_q   <= ml_q[MULT_LATENCY-1];
      rdot_q <= dot_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Accumulate with saturation
  //
  // first_q marks that the next valid beat opens a burst; its dot sum is
  // loaded (added to zero) and the sticky overflow restarts from that beat.
  // The add is done one bit wider than either operand so the comparison
  // against the ACC_WIDTH range can never itself wrap.
  // ---------------------------------------------------------------------------
  logic                           first_q;
  logic [1:0][1:0][ACC_WIDTH-1:0] acc_q;
  logic [1:0][1:0]                ovf_q;
  logic [1:0][1:0][ADD_W-1:0]     add_sum;
  logic [1:0][1:0][ACC_WIDTH-1:0] sat_d;
  logic [1:0][1:0]                ovf_d;

  always_comb begin
    add_sum = '0;
    sat_d   = '0;
    ovf_d   = '0;
    for (int f = 0; f < 2; f++) begin
      for (int g = 0; g < 2; g++) begin
        add_sum[f][g] = (first_q ? {ADD_W{1'b0}}
                                 : {{(ADD_W-ACC_WIDTH){acc_q[f][g][ACC_WIDTH-1]}}, acc_q[f][g]})
                      + {{(ADD_W-SUM_W){rdot_q[f][g][SUM_W-1]}}, rdot_q[f][g]};
        ovf_d[f][g] = first_q ? 1'b0 : ovf_q[f][g];
        if ($signed(add_sum[f][g]) > $signed(ACC_MAX)) begin
          sat_d[f][g] = ACC_MAX[ACC_WIDTH-1:0];
          ovf_d[f][g] = 1'b1;
        end else if ($signed(add_sum[f][g]) < $signed(ACC_MIN)) begin
          sat_d[f][g] = ACC_MIN[ACC_WIDTH-1:0];
          ovf_d[f][g] = 1'b1;
        end else begin
          sat_d[f][g] = add_sum[f][g][ACC_WIDTH-1:0];
        end
      end
    end
  end

  logic                           o_valid_q;
  logic [1:0][1:0][ACC_WIDTH-1:0] o_result_q;
  logic [1:0][1:0]                o_overflow_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      first_q      <= 1'b1;
      acc_q        <= '0;
      ovf_q        <= '0;
      o_valid_q    <= 1'b0;
      o_result_q   <= '0;
      o_overflow_q <= '0;
    end else begin
      o_valid_q <= 1'b0;
      if (rv_q) begin
        if (rl_q) begin
          // Present the burst and clear so the next valid beat opens a new one.
          o_valid_q    <= 1'b1;
          o_result_q   <= sat_d;
          o_overflow_q <= ovf_d;
          acc_q        <= '0;
          ovf_q        <= '0;
          first_q      <= 1'b1;
        end else begin
          acc_q   <= sat_d;
          ovf_q   <= ovf_d;
          first_q <= 1'b0;
        end
      end
    end
  end

  assign o_valid    = o_valid_q;
  assign o_result   = o_result_q;
  assign o_overflow = o_overflow_q;

endmodule

// File: tb/tb_pe_dot_packed_mac.sv
// tb/tb_pe_dot_packed_mac.sv - self-checking bench for pe_dot_packed_mac
//
// Two instances share the same stimulus: one at the default ACC_WIDTH=16 and
// one at ACC_WIDTH=8 so saturation is exercised. Expected outputs come from a
// cycle-scheduled arithmetic model of the burst sums.

module tb_pe_dot_packed_mac;

  localparam int DOT  = 4;
  localparam int M    = 3;
  localparam int ML   = 3;
  localparam int L    = ML + 2;
  localparam int MAXC = 4096;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic                       reset;
  logic                       i_valid;
  logic                       i_last;
  logic [1:0][DOT-1:0][M:0]   i_feature;
  logic [1:0][DOT-1:0][M:0]   i_filter;

  logic                       o_valid_a;
  logic [1:0][1:0][15:0]      o_result_a;
  logic [1:0][1:0]            o_overflow_a;
  logic                       o_valid_b;
  logic [1:0][1:0][7:0]       o_result_b;
  logic [1:0][1:0]            o_overflow_b;

  pe_dot_packed_mac #(.DOT_SIZE(DOT), .MAG_WIDTH(M), .MULT_LATENCY(ML), .ACC_WIDTH(16)) u_dut_a (
    .clock(clock), .reset(reset), .i_valid(i_valid), .i_last(i_last),
    .i_feature(i_feature), .i_filter(i_filter),
    .o_valid(o_valid_a), .o_result(o_result_a), .o_overflow(o_overflow_a)
  );

  pe_dot_packed_mac #(.DOT_SIZE(DOT), .MAG_WIDTH(M), .MULT_LATENCY(ML), .ACC_WIDTH(8)) u_dut_b (
    .clock(clock), .reset(reset), .i_valid(i_valid), .i_last(i_last),
    .i_feature(i_feature), .i_filter(i_filter),
    .o_valid(o_valid_b), .o_result(o_result_b), .o_overflow(o_overflow_b)
  );

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  // Operand values chosen by the bench: sign bit and magnitude per element.
  bit fs[2][DOT];
  bit gs[2][DOT];
  int fm[2][DOT];
  int gm[2][DOT];

  // Scheduled expectations, indexed by the edge count after which they show.
  bit     reset_at[MAXC];
  bit     exp_v[MAXC];
  longint exp_r[MAXC][2][2][2];
  bit     exp_o[MAXC][2][2][2];

  // Model burst state, [instance][f][g]; instance 0 = 16-bit, 1 = 8-bit.
  longint macc[2][2][2];
  bit     movf[2][2][2];
  bit     mfirst = 1'b1;

  longint held_r[2][2][2];
  bit     held_o[2][2][2];

  function automatic int sval(input bit s, input int m);
    return s ? -m : m;
  endfunction

  task automatic model_edge(input int e, input bit rst, input bit v, input bit l);
    longint dot, lim, t;
    bit sat, o;
    if (rst) begin
      reset_at[e] = 1'b1;
      for (int i = e; i < e + L + 2 && i < MAXC; i++) exp_v[i] = 1'b0;
      for (int k = 0; k < 2; k++)
        for (int f = 0; f < 2; f++)
          for (int g = 0; g < 2; g++) begin
            macc[k][f][g] = 0;
            movf[k][f][g] = 1'b0;
          end
      mfirst = 1'b1;
    end else if (v) begin
      for (int f = 0; f < 2; f++) begin
        for (int g = 0; g < 2; g++) begin
          dot = 0;
          for (int d = 0; d < DOT; d++) dot += sval(fs[f][d], fm[f][d]) * sval(gs[g][d], gm[g][d]);
          for (int k = 0; k < 2; k++) begin
            lim = (k == 0) ? 32767 : 127;
            t   = (mfirst ? 0 : macc[k][f][g]) + dot;
            sat = 1'b0;
            if (t > lim) begin t = lim; sat = 1'b1; end
            else if (t < -lim - 1) begin t = -lim - 1; sat = 1'b1; end
            o = (mfirst ? 1'b0 : movf[k][f][g]) | sat;
            if (l) begin
              exp_r[e+L][k][f][g] = t;
              exp_o[e+L][k][f][g] = o;
              macc[k][f][g] = 0;
              movf[k][f][g] = 1'b0;
            end else begin
              macc[k][f][g] = t;
              movf[k][f][g] = o;
            end
          end
        end
      end
      if (l) exp_v[e+L] = 1'b1;
      mfirst = l;
    end
  endtask

  task automatic step(input bit rst, input bit v, input bit l);
    reset   = rst;
    i_valid = v;
    i_last  = l;
    for (int f = 0; f < 2; f++)
      for (int d = 0; d < DOT; d++) begin
        i_feature[f][d] = {fs[f][d], 3'(fm[f][d])};
        i_filter[f][d]  = {gs[f][d], 3'(gm[f][d])};
      end
    model_edge(cyc + 1, rst, v, l);
    @(negedge clock);
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic set_all(input int f0, input int f1, input int g0, input int g1);
    for (int d = 0; d < DOT; d++) begin
      fs[0][d] = f0 < 0; fm[0][d] = (f0 < 0) ? -f0 : f0;
      fs[1][d] = f1 < 0; fm[1][d] = (f1 < 0) ? -f1 : f1;
      gs[0][d] = g0 < 0; gm[0][d] = (g0 < 0) ? -g0 : g0;
      gs[1][d] = g1 < 0; gm[1][d] = (g1 < 0) ? -g1 : g1;
    end
  endtask

  task automatic rand_ops();
    for (int i = 0; i < 2; i++)
      for (int d = 0; d < DOT; d++) begin
        fs[i][d] = 1'($urandom_range(0, 1));
        gs[i][d] = 1'($urandom_range(0, 1));
        fm[i][d] = ($urandom_range(0, 3) == 0) ? 7 : int'($urandom_range(0, 7));
        gm[i][d] = ($urandom_range(0, 3) == 0) ? 7 : int'($urandom_range(0, 7));
      end
  endtask

  // Per-cycle checker against the scheduled model.
  logic [1:0][1:0][15:0] pr_a;
  logic [1:0][1:0][7:0]  pr_b;
  logic [1:0][1:0]       po_a;
  logic [1:0][1:0]       po_b;

  always @(negedge clock) begin
    if (cyc < MAXC) begin
      if (reset_at[cyc]) begin
        for (int k = 0; k < 2; k++)
          for (int f = 0; f < 2; f++)
            for (int g = 0; g < 2; g++) begin
              held_r[k][f][g] = 0;
              held_o[k][f][g] = 1'b0;
            end
      end
      if (exp_v[cyc]) begin
        for (int k = 0; k < 2; k++)
          for (int f = 0; f < 2; f++)
            for (int g = 0; g < 2; g++) begin
              held_r[k][f][g] = exp_r[cyc][k][f][g];
              held_o[k][f][g] = exp_o[cyc][k][f][g];
            end
      end
      for (int f = 0; f < 2; f++)
        for (int g = 0; g < 2; g++) begin
          pr_a[f][g] = 16'(held_r[0][f][g]);
          pr_b[f][g] = 8'(held_r[1][f][g]);
          po_a[f][g] = held_o[0][f][g];
          po_b[f][g] = held_o[1][f][g];
        end
      check("o_valid_a", 64'(o_valid_a), 64'(exp_v[cyc]));
      check("o_valid_b", 64'(o_valid_b), 64'(exp_v[cyc]));
      check("o_result_a", 64'(o_result_a), 64'(pr_a));
      check("o_result_b", 64'(o_result_b), 64'(pr_b));
      check("o_overflow_a", 64'(o_overflow_a), 64'(po_a));
      check("o_overflow_b", 64'(o_overflow_b), 64'(po_b));
    end
  end

  function automatic longint sa(input logic [15:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint sb(input logic [7:0] v);
    return longint'($signed(v));
  endfunction

  int e, e2, nb, nbub;

  initial begin
    set_all(0, 0, 0, 0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("reset_valid", 64'(o_valid_a), 64'd0);
    check("reset_result", 64'(o_result_a), 64'd0);
    check("reset_overflow", 64'(o_overflow_b), 64'd0);

    // Single beat and latency
    set_all(7, -7, 7, 1);
    e = cyc + 1;
    step(1'b0, 1'b1, 1'b1);
    wait_to(e + L - 1);
    check("single_early", 64'(o_valid_a), 64'd0);
    step(1'b0, 1'b0, 1'b0);
    check("single_pulse", 64'(o_valid_a), 64'd1);
    check("single_00", 64'(sa(o_result_a[0][0])), 64'(196));
    check("single_01", 64'(sa(o_result_a[0][1])), 64'(28));
    check("single_10", 64'(sa(o_result_a[1][0])), 64'(-196));
    check("single_11", 64'(sa(o_result_a[1][1])), 64'(-28));
    check("single_ovf", 64'(o_overflow_a), 64'd0);
    step(1'b0, 1'b0, 1'b0);
    check("single_late", 64'(o_valid_a), 64'd0);

    // Negative zero
    set_all(0, 7, 7, 7);
    for (int d = 0; d < DOT; d++) fs[0][d] = 1'b1;
    e = cyc + 1;
    step(1'b0, 1'b1, 1'b1);
    wait_to(e + L);
    check("negzero_00", 64'(sa(o_result_a[0][0])), 64'd0);
    check("negzero_01", 64'(sa(o_result_a[0][1])), 64'd0);
    set_all(0, 1, 2, 1);
    fm[0][0] = 3; fs[0][0] = 1'b0;
    fm[0][1] = 3; fs[0][1] = 1'b1;
    fm[0][2] = 5; fs[0][2] = 1'b0;
    fm[0][3] = 5; fs[0][3] = 1'b1;
    e = cyc + 1;
    step(1'b0, 1'b1, 1'b1);
    wait_to(e + L);
    check("mixed_00", 64'(sa(o_result_a[0][0])), 64'd0);

    // Burst with bubbles
    set_all(1, 1, 1, 1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    e = cyc + 1;
    step(1'b0, 1'b1, 1'b1);
    wait_to(e + L);
    for (int f = 0; f < 2; f++)
      for (int g = 0; g < 2; g++)
        check($sformatf("bubble_%0d%0d", f, g), 64'(sa(o_result_a[f][g])), 64'(12));

    // Saturation on the 8-bit instance, then a clean burst
    set_all(7, -7, 7, 1);
    step(1'b0, 1'b1, 1'b0);
    e = cyc + 1;
    step(1'b0, 1'b1, 1'b1);
    set_all(1, 1, 1, 1);
    e2 = cyc + 1;
    step(1'b0, 1'b1, 1'b1);
    wait_to(e + L);
    check("sat_00", 64'(sb(o_result_b[0][0])), 64'(127));
    check("sat_10", 64'(sb(o_result_b[1][0])), 64'(-128));
    check("sat_01", 64'(sb(o_result_b[0][1])), 64'(56));
    check("sat_11", 64'(sb(o_result_b[1][1])), 64'(-56));
    check("sat_ovf", 64'(o_overflow_b), 64'(4'b0101));
    wait_to(e2 + L);
    check("sat_next_00", 64'(sb(o_result_b[0][0])), 64'(4));
    check("sat_next_ovf", 64'(o_overflow_b), 64'd0);

    // Reset mid-burst with beats in flight
    set_all(7, 7, 7, 7);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    set_all(1, 1, 1, 1);
    e = cyc + 1;
    step(1'b0, 1'b1, 1'b1);
    wait_to(e + L);
    for (int f = 0; f < 2; f++)
      for (int g = 0; g < 2; g++)
        check($sformatf("rstmid_%0d%0d", f, g), 64'(sa(o_result_a[f][g])), 64'(4));

    // Back-to-back single-beat bursts
    set_all(7, 7, 7, 7);
    e = cyc + 1;
    step(1'b0, 1'b1, 1'b1);
    set_all(1, 1, 1, 1);
    step(1'b0, 1'b1, 1'b1);
    wait_to(e + L);
    check("b2b_first_valid", 64'(o_valid_a), 64'd1);
    check("b2b_first_00", 64'(sa(o_result_a[0][0])), 64'(196));
    step(1'b0, 1'b0, 1'b0);
    check("b2b_second_valid", 64'(o_valid_a), 64'd1);
    check("b2b_second_00", 64'(sa(o_result_a[0][0])), 64'(4));

    // Randomized bursts, checked every cycle by the scheduled model
    for (int b = 0; b < 60; b++) begin
      nb = int'($urandom_range(1, 4));
      for (int k = 0; k < nb; k++) begin
        nbub = int'($urandom_range(0, 2));
        for (int j = 0; j < nbub; j++) begin
          rand_ops();
          step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
        end
        if ($urandom_range(0, 19) == 0) begin
          step(1'b1, 1'b0, 1'b0);
          if ($urandom_range(0, 1) == 1) step(1'b1, 1'b0, 1'b0);
        end
        rand_ops();
        step(1'b0, 1'b1, k == nb - 1);
      end
    end
    repeat (L + 3) step(1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
